// File: rtl/banked_memory.sv
// rtl/banked_memory.sv - two-stage banked ROM/SRAM with write-protect errors and a saturating error counter
module banked_memory #(
    parameter int DATA_W    = 8,
    parameter int WORD_W    = 3,
    parameter int N_BANKS   = 8,
    parameter int BANK_W    = 3,
    parameter int ERR_CNT_W = 8,
    localparam int ADDR_W   = 1 + BANK_W + WORD_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    din,
    output logic                 rsp_valid,
    output logic [DATA_W-1:0]    dout,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam int DEPTH = 2 ** WORD_W;
    localparam int IDX_W = BANK_W + WORD_W;

    // Fibonacci term with F(0)=F(1)=1, wrapping at DATA_W bits.
    function automatic logic [DATA_W-1:0] fib(input int n);
        logic [DATA_W-1:0] a, b, t;
        a = DATA_W'(1);
        b = DATA_W'(1);
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    logic [DATA_W-1:0] rom_base [DEPTH];
    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom_base[g] = fib(g);
    end

    logic              region;
    logic [BANK_W-1:0] bank;
    logic [WORD_W-1:0] word;
    logic [IDX_W-1:0]  idx;
    logic              bank_ok;
    logic              req_err;
    logic              sram_wr;
    logic [DATA_W-1:0] rd_word;

    assign {region, bank, word} = addr;
    assign idx     = {bank, word};
    assign bank_ok = 32'(bank) < N_BANKS;
    assign req_err = !bank_ok || (!region && we);
    assign sram_wr = req && we && region && bank_ok && !rst;

    logic [DATA_W-1:0] mem [N_BANKS*DEPTH];

    always_comb begin
        rd_word = '0;
        if (bank_ok) begin
            if (region)
                rd_word = mem[idx];
            else
                rd_word = rom_base[word] + DATA_W'(bank);
        end
    end

    // Storage is never reset; the read samples pre-write contents (read-first).
    logic [DATA_W-1:0] s1_data;
    always_ff @(posedge clk) begin
        if (sram_wr)
            mem[idx] <= din;
        if (req)
            s1_data <= rd_word;
    end

    logic s1_valid, s1_err, s1_we;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_we    <= 1'b0;
        end else begin
            s1_valid <= req;
            if (req) begin
                s1_err <= req_err;
                s1_we  <= we;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            dout      <= '0;
            err       <= 1'b0;
            err_cnt   <= '0;
        end else begin
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                err  <= s1_err;
                dout <= (s1_err || s1_we) ? '0 : s1_data;
                if (s1_err && err_cnt != '1)
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_banked_memory.sv
// tb/tb_banked_memory.sv - directed self-checking bench for banked_memory
module tb_banked_memory;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic       req5 = 1'b0;
    logic       we = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] din = '0;

    logic       rsp_valid, err;
    logic [7:0] dout, err_cnt;
    logic       rsp_valid5, err5;
    logic [7:0] dout5;
    logic [1:0] err_cnt5;

    int tests = 0;
    int fails = 0;
    int vcount;
    logic [7:0] rom_exp [9];
    logic [6:0] rom_addr [9];

    always #5 clk = ~clk;

    banked_memory dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .din(din),
        .rsp_valid(rsp_valid), .dout(dout), .err(err), .err_cnt(err_cnt)
    );

    banked_memory #(.N_BANKS(5), .BANK_W(3), .ERR_CNT_W(2)) dut5 (
        .clk(clk), .rst(rst), .req(req5), .we(we), .addr(addr), .din(din),
        .rsp_valid(rsp_valid5), .dout(dout5), .err(err5), .err_cnt(err_cnt5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Isolated request on the default instance; checks the response two edges later.
    task automatic xact(input string tag, input logic w, input logic [6:0] a,
                        input logic [7:0] d, input logic [7:0] ed, input logic ee);
        @(negedge clk); req = 1'b1; we = w; addr = a; din = d;
        @(posedge clk); #1;
        @(negedge clk); req = 1'b0;
        @(posedge clk); #1;
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_dout"}, 32'(dout), 32'(ed));
        check({tag, "_err"}, 32'(err), 32'(ee));
    endtask

    task automatic xact5(input string tag, input logic [6:0] a, input logic [7:0] ed,
                         input logic ee, input logic [1:0] ecnt);
        @(negedge clk); req5 = 1'b1; we = 1'b0; addr = a;
        @(posedge clk); #1;
        @(negedge clk); req5 = 1'b0;
        @(posedge clk); #1;
        check({tag, "_valid"}, 32'(rsp_valid5), 32'd1);
        check({tag, "_dout"}, 32'(dout5), 32'(ed));
        check({tag, "_err"}, 32'(err5), 32'(ee));
        check({tag, "_cnt"}, 32'(err_cnt5), 32'(ecnt));
    endtask

    initial begin
        rom_exp  = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd26};
        rom_addr = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd47};

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk); rst = 1'b0;

        // Streamed ROM reads: response to request i-1 is visible after edge i.
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            req = (i < 9);
            we = 1'b0;
            addr = (i < 9) ? rom_addr[i] : 7'd0;
            @(posedge clk); #1;
            if (rsp_valid) vcount++;
            check($sformatf("rom_valid_%0d", i), 32'(rsp_valid), 32'((i >= 1) && (i <= 9)));
            if (i >= 1 && i <= 9)
                check($sformatf("rom_dout_%0d", i - 1), 32'(dout), 32'(rom_exp[i-1]));
        end
        check("rom_valid_count", 32'(vcount), 32'd9);

        xact("wr_100", 1'b1, 7'd64, 8'd5, 8'd0, 1'b0);
        xact("rd_100", 1'b0, 7'd64, 8'd0, 8'd5, 1'b0);
        xact("wr_131", 1'b1, 7'd89, 8'd15, 8'd0, 1'b0);
        xact("rd_131", 1'b0, 7'd89, 8'd0, 8'd15, 1'b0);

        // Write then read of the same word on consecutive edges.
        @(negedge clk); req = 1'b1; we = 1'b1; addr = 7'd84; din = 8'hAA;
        @(posedge clk); #1;
        @(negedge clk); we = 1'b0; din = 8'h00;
        @(posedge clk); #1;
        check("b2b_wr_valid", 32'(rsp_valid), 32'd1);
        check("b2b_wr_dout", 32'(dout), 32'd0);
        check("b2b_wr_err", 32'(err), 32'd0);
        @(negedge clk); req = 1'b0;
        @(posedge clk); #1;
        check("b2b_rd_valid", 32'(rsp_valid), 32'd1);
        check("b2b_rd_dout", 32'(dout), 32'hAA);
        @(posedge clk); #1;
        check("b2b_idle_valid", 32'(rsp_valid), 32'd0);

        xact("rom_wr", 1'b1, 7'd9, 8'h77, 8'd0, 1'b1);
        check("rom_wr_cnt", 32'(err_cnt), 32'd1);
        xact("rom_rd_after_wr", 1'b0, 7'd9, 8'd0, 8'd2, 1'b0);
        check("rom_rd_cnt", 32'(err_cnt), 32'd1);

        xact5("nb5_e1", 7'd112, 8'd0, 1'b1, 2'd1);
        xact5("nb5_e2", 7'd112, 8'd0, 1'b1, 2'd2);
        xact5("nb5_e3", 7'd112, 8'd0, 1'b1, 2'd3);
        xact5("nb5_e4", 7'd112, 8'd0, 1'b1, 2'd3);
        xact5("nb5_e5", 7'd112, 8'd0, 1'b1, 2'd3);
        xact5("nb5_rom_ok", 7'd34, 8'd6, 1'b0, 2'd3);

        // Three back-to-back reads, reset raised mid-cycle after the second edge.
        @(negedge clk); req = 1'b1; we = 1'b0; addr = 7'd8;
        @(posedge clk); #1;
        @(negedge clk); addr = 7'd16;
        @(posedge clk); #1;
        check("pre_rst_valid", 32'(rsp_valid), 32'd1);
        check("pre_rst_dout", 32'(dout), 32'd2);
        addr = 7'd24;
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(rsp_valid), 32'd0);
        check("async_rst_dout", 32'(dout), 32'd0);
        check("async_rst_err", 32'(err), 32'd0);
        check("async_rst_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk); req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("post_rst_idle_%0d", i), 32'(rsp_valid), 32'd0);
        end
        xact("post_rst_rd", 1'b0, 7'd3, 8'd0, 8'd3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/banked_memory.md
# banked_memory

Parametrised banked memory combining a read-only constant region and a writable SRAM region behind one request/response port. It generalises the fixed 8-bank, 8x8 ROM/SRAM array to configurable data width, bank depth and bank count. It adds a pipelined valid handshake, write-protect error reporting and a saturating error counter. It sits between a simple master (testbench or datapath controller) and local storage.

## Interface

Parameters:
- DATA_W, 8, data word width in bits.
- WORD_W, 3, word-address width per bank; bank depth is 2^WORD_W.
- N_BANKS, 8, banks per region, range 1..2^BANK_W.
- BANK_W, 3, bank-select width; must satisfy 2^BANK_W >= N_BANKS.
- ERR_CNT_W, 8, width of the error counter.

Derived:
- ADDR_W = 1 + BANK_W + WORD_W.
- addr layout = {region, bank, word}; region 0 = ROM, region 1 = SRAM.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock; asynchronous, active-high.
- req  in  1  request strobe, sampled each rising edge.
- we  in  1  write request when high, read when low; qualified by req.
- addr  in  ADDR_W  request address.
- din  in  DATA_W  write data.
- rsp_valid  out  1  response strobe, one cycle per accepted request.
- dout  out  DATA_W  read data; 0 on writes and on errors.
- err  out  1  error flag qualified by rsp_valid.
- err_cnt  out  ERR_CNT_W  count of erroneous requests, saturating.

## Operation

- Every cycle with req=1 is accepted. There is no back-pressure, and back-to-back requests are allowed.
- ROM contents are a constant function with no storage to initialise:
  - word w of ROM bank b = (F(w) + b) mod 2^DATA_W.
  - F is the Fibonacci sequence F(0)=1, F(1)=1, F(n)=F(n-1)+F(n-2), computed in DATA_W-bit wraparound arithmetic.
- SRAM region: N_BANKS banks of 2^WORD_W x DATA_W. Contents are not reset; a read before any write returns X.
- Error conditions:
  - bank >= N_BANKS in either region: write dropped, read returns 0, err=1.
  - write to the ROM region: write dropped, err=1, no storage changes.
- Reads with err=0: dout = addressed word. Writes with err=0: dout=0, err=0, and a response is still issued.
- err_cnt increments by 1 for each response with err=1 and holds at 2^ERR_CNT_W-1.
- Read-during-write to the same SRAM word in the same cycle is read-first: the read returns old data.
- Same-cycle read and write cannot occur on the one port. "Same-address" here means a write at edge T followed by a read at edge T+1; that read returns the new data.

## Timing

- Pipeline stage 1, at edge T with req=1:
  - decode the address and perform the SRAM write if legal;
  - sample the ROM/SRAM word into the stage-1 data register;
  - latch the valid, error and write flags.
- Pipeline stage 2, at edge T+1: the output mux registers dout, err and rsp_valid; err_cnt updates at the same edge.
- Fixed latency is 2 edges: rsp_valid is high during the cycle after edge T+1, exactly once per accepted request, in request order.
- With req=0 at edge T, rsp_valid=0 after T+1. dout and err hold their last values but are meaningful only with rsp_valid=1.
- Reset values: rsp_valid=0, dout=0, err=0, err_cnt=0, stage-1 valid=0.
- Reset asserted mid-operation: all in-flight requests are discarded with no response.
  - A write sampled at an edge before rst rose is retained.
  - No write occurs while rst=1.
- After rst deasserts, the first req is accepted on the next rising edge.
- err_cnt at saturation: further errors still assert err, and the count holds.

## Test plan

- Default params, reset, then ROM reads addr {0,0,0..7}, then {0,5,7}.
  - Required: dout 1,1,2,3,5,8,13,21 on consecutive cycles, each 2 edges after its request, then 26.
  - Required: rsp_valid high exactly 9 cycles.
- Write SRAM {1,0,0}=5, then read {1,0,0}; write {1,3,1}=15, then read {1,3,1}.
  - Required: reads return 5 and 15; write responses have dout=0, err=0.
- Back-to-back: write {1,2,4}=0xAA at edge T, read same address at edge T+1.
  - Required: read returns 0xAA at T+2's following cycle, with no bubble between responses.
- Write {0,1,1}=0x77.
  - Required: err=1 with rsp_valid, err_cnt=1, and a subsequent read of {0,1,1} returns 2.
- N_BANKS=5, BANK_W=3: read {1,6,0}.
  - Required: dout=0, err=1.
  - ERR_CNT_W=2: 5 errors give err_cnt 1,2,3,3,3.
- Issue 3 consecutive reads, assert rst asynchronously mid-cycle after the second edge.
  - Required: outputs go to reset values immediately and no rsp_valid appears for the discarded requests.
  - Required: a read issued after release responds normally.
